// File: rtl/serial_pkg.sv
// Shared types and helpers for the multi-channel serial pump.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        READ,
        WAIT_Q,
        SEND,
        SENT
    } state_t;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hF0;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_rr_picker.sv
// Round-robin first-set search over the request vector, starting at ptr and wrapping.
module serial_rr_picker #(
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [CH_W-1:0]     ptr,
    output logic [CH_W-1:0]     grant,
    output logic                any
);

    // Walk offsets from farthest to nearest so the closest requester after ptr wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % CHANNELS]) begin
                grant = CH_W'((int'(ptr) + i) % CHANNELS);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_mux_pump.sv
// Drains several byte FIFOs into one UART TX with round-robin bursts and ack timeout.
// Define SERIAL_MUX_TAG_EN to prefix each grant with a TAG_BASE+channel tag byte.
module serial_mux_pump
    import serial_pkg::*;
#(
    parameter int                CHANNELS    = 2,
    parameter int                DATA_W      = 8,
    parameter int                BURST_MAX   = 4,
    parameter int                ACK_TIMEOUT = 1023,
    parameter logic [DATA_W-1:0] TAG_BASE    = DATA_W'(TAG_BASE_DEFAULT),
    localparam int               CH_W        = ch_w(CHANNELS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          fifo_empty,
    output logic [CHANNELS-1:0]          fifo_rdreq,
    input  logic [CHANNELS*DATA_W-1:0]   fifo_q,
    input  logic                         uart_busy,
    output logic [DATA_W-1:0]            uart_data,
    output logic                         data_valid,
    output logic [CH_W-1:0]              active_ch,
    output logic                         drop_err
);

    localparam int               BC_W    = $clog2(BURST_MAX + 1);
    localparam int               TO_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(BURST_MAX);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_next;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   next_ptr;
    logic [BC_W-1:0]   burst_cnt;
    logic [BC_W-1:0]   burst_inc;
    logic [TO_W-1:0]   to_cnt;
    logic              tag_sent;
    logic              hit_timeout;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;

    serial_rr_picker #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W)
    ) u_picker (
        .req   (~fifo_empty),
        .ptr   (rr_ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign next_ptr  = (int'(active_ch) == CHANNELS - 1) ? '0 : active_ch + 1'b1;
    assign burst_inc = burst_cnt + 1'b1;

    always_comb begin
        state_next  = state;
        hit_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (!uart_busy && pick_any) begin
`ifdef SERIAL_MUX_TAG_EN
                    state_next = TAG;
`else
                    state_next = READ;
`endif
                end
            end
            TAG:    state_next = SEND;
            READ:   state_next = WAIT_Q;
            WAIT_Q: state_next = SEND;
            SEND: begin
                if (uart_busy) begin
                    state_next = SENT;
                end else if (ACK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
                    state_next  = IDLE;
                    hit_timeout = 1'b1;
                end
            end
            SENT: begin
                if (!uart_busy) begin
                    // Tags never consume burst budget; only data bytes do.
                    if (tag_sent || (burst_inc < BC_MAX && !fifo_empty[active_ch])) begin
                        state_next = READ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            to_cnt     <= '0;
            tag_sent   <= 1'b0;
            active_ch  <= '0;
            uart_data  <= '0;
            data_valid <= 1'b0;
            drop_err   <= 1'b0;
            fifo_rdreq <= '0;
        end else begin
            state      <= state_next;
            fifo_rdreq <= '0;
            drop_err   <= hit_timeout;
            case (state)
                IDLE: begin
                    if (state_next != IDLE) begin
                        active_ch <= pick_idx;
                        burst_cnt <= '0;
                        tag_sent  <= 1'b0;
                        if (state_next == READ) begin
                            fifo_rdreq <= CHANNELS'(1) << pick_idx;
                        end
                    end
                end
                TAG: begin
                    uart_data  <= TAG_BASE + DATA_W'(active_ch);
                    data_valid <= 1'b1;
                    tag_sent   <= 1'b1;
                    to_cnt     <= '0;
                end
                WAIT_Q: begin
                    uart_data  <= fifo_q[int'(active_ch)*DATA_W +: DATA_W];
                    data_valid <= 1'b1;
                    to_cnt     <= '0;
                end
                SEND: begin
                    if (state_next == SEND) begin
                        to_cnt <= to_cnt + 1'b1;
                    end else begin
                        data_valid <= 1'b0;
                    end
                    if (hit_timeout) begin
                        rr_ptr <= next_ptr;
                    end
                end
                SENT: begin
                    if (state_next == READ) begin
                        fifo_rdreq <= CHANNELS'(1) << active_ch;
                        if (tag_sent) begin
                            tag_sent <= 1'b0;
                        end else begin
                            burst_cnt <= burst_inc;
                        end
                    end else if (state_next == IDLE) begin
                        rr_ptr <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mux_pump.sv
// Directed bench for serial_mux_pump: FIFO and UART models, burst/rotation, timeout, reset.
module tb_serial_mux_pump;

    localparam int CH = 3;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     fifo_empty;
    logic [CH-1:0]     fifo_rdreq;
    logic [CH*DW-1:0]  fifo_q = '0;
    logic              uart_busy = 1'b0;
    logic [DW-1:0]     uart_data;
    logic              data_valid;
    logic [1:0]        active_ch;
    logic              drop_err;

    bit                uart_en = 1'b1;
    int                checks = 0;
    int                passes = 0;

    logic [DW-1:0]     mem [CH][32];
    int                wr [CH] = '{0, 0, 0};
    int                rd [CH] = '{0, 0, 0};

    int                ucnt = 0;
    int                cyc = 0;
    logic [DW-1:0]     log_data [64];
    int                log_ch [64];
    int                log_cyc [64];
    int                log_n = 0;

    serial_mux_pump #(
        .CHANNELS    (CH),
        .DATA_W      (DW),
        .BURST_MAX   (4),
        .ACK_TIMEOUT (8),
        .TAG_BASE    (8'hF0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .fifo_q     (fifo_q),
        .uart_busy  (uart_busy),
        .uart_data  (uart_data),
        .data_valid (data_valid),
        .active_ch  (active_ch),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data one cycle after the rdreq edge.
    always @(posedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (fifo_rdreq[i] && rd[i] != wr[i]) begin
                fifo_q[i*DW +: DW] <= mem[i][rd[i] % 32];
                rd[i] <= rd[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            fifo_empty[i] = (rd[i] == wr[i]);
        end
    end

    // UART model: busy rises one cycle after data_valid, stays high five cycles, logs the byte.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ucnt > 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) uart_busy <= 1'b0;
        end else if (uart_en && data_valid && !uart_busy) begin
            ucnt              <= 5;
            uart_busy         <= 1'b1;
            log_data[log_n]   <= uart_data;
            log_ch[log_n]     <= int'(active_ch);
            log_cyc[log_n]    <= cyc;
            log_n             <= log_n + 1;
        end
    end

    task automatic applyStimulus(input int ch, input logic [DW-1:0] b);
        mem[ch][wr[ch] % 32] = b;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic waitLog(input int target, input int limit);
        int n = 0;
        while (log_n < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (log_n < target) checkOutput("wait_log", log_n, target);
    endtask

    task automatic waitDv(input int limit);
        int n = 0;
        while (!data_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!data_valid) checkOutput("wait_dv", data_valid, 1);
    endtask

    task automatic checkZero(input string tag);
        checkOutput({tag, "_rdreq"}, fifo_rdreq, 0);
        checkOutput({tag, "_data"}, uart_data, 0);
        checkOutput({tag, "_dv"}, data_valid, 0);
        checkOutput({tag, "_ch"}, active_ch, 0);
        checkOutput({tag, "_drop"}, drop_err, 0);
    endtask

    initial begin
        int base;
        int hi;
        int n;
        logic [DW-1:0] exp_d [15];
        int exp_c [15];

        uart_en = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        checkZero("reset");

`ifdef SERIAL_MUX_TAG_EN
        // Tag precedes each grant and does not count toward the burst of four.
        applyStimulus(1, 8'h11);
        applyStimulus(1, 8'h22);
        applyStimulus(1, 8'h33);
        applyStimulus(1, 8'h44);
        applyStimulus(1, 8'h55);
        base  = log_n;
        reset = 1'b0;
        waitLog(base + 7, 600);
        exp_d[0] = 8'hF1; exp_d[1] = 8'h11; exp_d[2] = 8'h22; exp_d[3] = 8'h33;
        exp_d[4] = 8'h44; exp_d[5] = 8'hF1; exp_d[6] = 8'h55;
        for (int k = 0; k < 7; k++) begin
            checkOutput($sformatf("tag_data%0d", k), log_data[base + k], exp_d[k]);
            checkOutput($sformatf("tag_ch%0d", k), log_ch[base + k], 1);
        end
`else
        // Single busy channel: ten bytes in order, IDLE gap after bytes 4 and 8.
        for (int k = 0; k < 10; k++) applyStimulus(0, 8'(k + 1));
        base  = log_n;
        reset = 1'b0;
        waitLog(base + 10, 400);
        for (int k = 0; k < 10; k++) begin
            checkOutput($sformatf("a_data%0d", k), log_data[base + k], 8'(k + 1));
            checkOutput($sformatf("a_ch%0d", k), log_ch[base + k], 0);
        end
        checkOutput("a_gap_1_2", log_cyc[base + 1] - log_cyc[base], 9);
        checkOutput("a_gap_4_5", log_cyc[base + 4] - log_cyc[base + 3], 10);
        checkOutput("a_gap_5_6", log_cyc[base + 5] - log_cyc[base + 4], 9);
        checkOutput("a_gap_8_9", log_cyc[base + 8] - log_cyc[base + 7], 10);

        // All three channels loaded with five bytes: rotation every four bytes.
        reset = 1'b1;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 5; k++) applyStimulus(c, 8'(8'hA0 + c*16 + k));
        repeat (8) @(negedge clk);
        n = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 4; k++) begin
                exp_d[n] = 8'(8'hA0 + c*16 + k);
                exp_c[n] = c;
                n++;
            end
        for (int c = 0; c < CH; c++) begin
            exp_d[n] = 8'(8'hA0 + c*16 + 4);
            exp_c[n] = c;
            n++;
        end
        base  = log_n;
        reset = 1'b0;
        waitLog(base + 15, 800);
        for (int k = 0; k < 15; k++) begin
            checkOutput($sformatf("b_data%0d", k), log_data[base + k], exp_d[k]);
            checkOutput($sformatf("b_ch%0d", k), log_ch[base + k], exp_c[k]);
        end

        // No acknowledge: byte dropped after eight SEND cycles, grant moves on.
        reset   = 1'b1;
        uart_en = 1'b0;
        applyStimulus(1, 8'h5A);
        applyStimulus(2, 8'h6B);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        waitDv(30);
        checkOutput("to_data1", uart_data, 8'h5A);
        checkOutput("to_ch1", active_ch, 1);
        hi = 0;
        while (data_valid && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("to_len", hi, 8);
        checkOutput("to_drop", drop_err, 1);
        @(negedge clk);
        checkOutput("to_drop_pulse", drop_err, 0);
        waitDv(30);
        checkOutput("to_data2", uart_data, 8'h6B);
        checkOutput("to_ch2", active_ch, 2);
        hi = 0;
        while (data_valid && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        checkOutput("to_drop2", drop_err, 1);

        // Reset lands while channel 1 is mid-read; its byte is lost, ch0 wins the restart.
        uart_en = 1'b1;
        applyStimulus(1, 8'h77);
        applyStimulus(1, 8'h78);
        n = 0;
        while (!fifo_rdreq[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rs_rdreq1", fifo_rdreq, 3'b010);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 8'hC0);
        @(negedge clk);
        checkZero("rs");
        base  = log_n;
        reset = 1'b0;
        waitLog(base + 2, 100);
        checkOutput("rs_first_ch", log_ch[base], 0);
        checkOutput("rs_first_data", log_data[base], 8'hC0);
        checkOutput("rs_next_ch", log_ch[base + 1], 1);
        checkOutput("rs_next_data", log_data[base + 1], 8'h78);
`endif

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/serial_mux_pump.md
# serial_mux_pump

Multi-channel successor to the single-FIFO serial pump: drains up to CHANNELS byte FIFOs into one shared UART transmitter. It uses round-robin grants with bounded bursts, a per-byte acknowledge timeout, and optional channel-tag framing. It sits between the capture FIFOs and the UART TX, and owns the FIFO read strobes and the TX data/valid handshake.

## Interface
- CHANNELS, 2: number of FIFO sources, 1..16.
- DATA_W, 8: byte width of FIFO data and UART data.
- BURST_MAX, 4: maximum bytes sent per grant before rotating, at least 1.
- ACK_TIMEOUT, 1023: cycles to wait for uart_busy after data_valid. 0 disables the timeout.
- TAG_BASE, 8'hF0: base value for tag bytes. Only used when SERIAL_MUX_TAG_EN is defined.
- clk  in  1  sole clock. All logic updates on the rising edge.
- reset  in  1  synchronous reset, active-high.
- fifo_empty  in  CHANNELS  per-channel empty flag.
- fifo_rdreq  out  CHANNELS  per-channel read strobe, one-hot or zero.
- fifo_q  in  CHANNELS*DATA_W  per-channel read data. Channel i occupies bits [i*DATA_W +: DATA_W]. Read latency is 1 cycle after the rdreq edge.
- uart_busy  in  1  TX busy. Rising acknowledges data; falling means the byte is sent.
- uart_data  out  DATA_W  byte presented to TX. Registered.
- data_valid  out  1  uart_data is valid. Registered.
- active_ch  out  CH_W  currently granted channel. CH_W = max(1, $clog2(CHANNELS)).
- drop_err  out  1  one-cycle pulse when a byte is dropped on timeout.

## Operation
- Reset values: fifo_rdreq=0, uart_data=0, data_valid=0, active_ch=0, drop_err=0, rr pointer=0, burst count=0, state=IDLE.
- IDLE: grant only when uart_busy=0 and some fifo_empty bit is 0.
  - Search starts at the rr pointer, wrapping modulo CHANNELS.
  - On grant: latch active_ch, clear the burst count, go to TAG if tagging is enabled, else READ.
- TAG: uart_data=TAG_BASE+active_ch and data_valid=1, then enter SEND with tag flag set.
- READ: fifo_rdreq[active_ch]=1 for exactly one cycle, then go to WAIT_Q.
- WAIT_Q: capture fifo_q slice into uart_data, set data_valid=1, go to SEND.
- SEND: hold data_valid and uart_data until uart_busy=1, then clear data_valid and go to SENT.
  - Timeout counter counts cycles in SEND.
  - Reaching ACK_TIMEOUT (when nonzero): clear data_valid, pulse drop_err, advance the rr pointer to active_ch+1, and go to IDLE. This ends the burst.
- SENT: wait for uart_busy=0.
  - If a tag was just sent: go to READ.
  - Else increment the burst count. If count<BURST_MAX and fifo_empty[active_ch]=0: go to READ (same channel, no new tag).
  - Else: set the rr pointer to active_ch+1 (wrap), and go to IDLE.
- The burst count increments only on data bytes, never on tags.
- fifo_empty is sampled only in IDLE and at the SENT burst decision. Mid-byte changes are ignored.
- A FIFO going empty between grant and READ is a producer contract violation; behaviour is undefined. The bench must not stimulate it.
- With CHANNELS=1: the rr pointer stays 0 and arbitration degenerates to the single-source pump.

## Timing
- The IDLE grant decision at edge E0 produces these edges:
  - fifo_rdreq high during E0→E1.
  - fifo_q valid during E1→E2.
  - uart_data/data_valid valid from E2 onward.
  - Grant to data_valid is 2 cycles without a tag.
  - With a tag, data_valid is asserted for the tag at E1.
- data_valid falls on the edge after uart_busy is first sampled high. Minimum data_valid high time is 1 cycle.
- A byte's SENT exit to the next byte's rdreq (burst continuation) is 1 cycle. Rotating through IDLE costs 1 extra cycle.
- Timeout fires on the ACK_TIMEOUT-th SEND cycle. drop_err is high for exactly 1 cycle, coincident with data_valid falling.
- Reset asserted in any state:
  - All outputs return to reset values at the next edge.
  - A pending rdreq is withdrawn, and a byte already read is lost.
  - The rr pointer returns to 0.

## Configuration
- SERIAL_MUX_TAG_EN defined: each grant sends one tag byte TAG_BASE+active_ch (DATA_W-wide, wraps) before its data bytes. TAG state exists.
- SERIAL_MUX_TAG_EN undefined: there is no TAG state, no tags are sent, and the stream is data bytes only.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, TAG, READ, WAIT_Q, SEND, SENT);
  - the CH_W computation function;
  - the TAG_BASE default constant.
- Sub-module serial_rr_picker: combinational round-robin first-set search over ~fifo_empty, starting at the pointer. Outputs a grant index and an any-valid flag.

## Test plan
- CHANNELS=2, BURST_MAX=4, no tag. Ch0 holds 10 bytes, ch1 is empty; uart_busy model is high 1 cycle after data_valid for 5 cycles.
  - Required: the 10 bytes appear in order.
  - active_ch stays 0, and there is a 1-cycle IDLE gap after bytes 4 and 8.
- CHANNELS=3, BURST_MAX=2, all channels holding bytes.
  - Required grant order: ch0,ch0,ch1,ch1,ch2,ch2,ch0…
- SERIAL_MUX_TAG_EN defined, TAG_BASE=8'hF0, ch1 holds {8'h11, 8'h22}.
  - Required uart_data sequence: F1, 11, 22.
  - The tag is counted outside BURST_MAX.
- ACK_TIMEOUT=8, uart_busy tied 0.
  - Required: data_valid falls after 8 SEND cycles, drop_err pulses once, and the next grant goes to the following channel.
- Reset asserted the cycle after fifo_rdreq[1] rises.
  - Required: all outputs are 0 next edge, and the restart grants ch0 first if it is non-empty.
